// File: rtl/mem_access_arbiter_if.sv
// Requester, XOR_RAM and ROM signals of mem_access_arbiter, bundled for port connection.
// slave = arbiter side, master = requesters plus RAM/ROM environment.
interface mem_access_arbiter_if;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          req_a;
  logic          req_b;
  logic          wr_a;
  logic          wr_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_a;
  logic [DW-1:0] wdata_b;
  logic          ack_a;
  logic          ack_b;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          ram_mode;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_mask;
  logic [DW-1:0] ram_data_out;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  modport slave (
    input  req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
    input  ram_data_out, rom_data,
    output ack_a, ack_b, rdata, busy,
    output ram_mode, ram_addr, ram_data_in, ram_mask, rom_addr
  );

  modport master (
    output req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
    output ram_data_out, rom_data,
    input  ack_a, ack_b, rdata, busy,
    input  ram_mode, ram_addr, ram_data_in, ram_mask, rom_addr
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter for one XOR_RAM, with ROM-supplied per-address encode/decode mask.
// Define ARB_ROM_MASK_EN to enable the ROM mask; otherwise storage is plain and the ROM is unused.
module mem_access_arbiter (
  input  logic                 CLK,
  input  logic                 RST_N,
  mem_access_arbiter_if.slave  arb
);
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic          r_prio,     w_prio_nxt;
  logic          r_win,      w_win_nxt;
  logic          r_wr,       w_wr_nxt;
  logic [AW-1:0] r_addr,     w_addr_nxt;
  logic [DW-1:0] r_wdata,    w_wdata_nxt;
  logic [DW-1:0] r_rdata,    w_rdata_nxt;
  logic          r_ack_a,    w_ack_a_nxt;
  logic          r_ack_b,    w_ack_b_nxt;
  logic          r_busy,     w_busy_nxt;
  logic          r_ram_mode, w_ram_mode_nxt;
  logic          w_grant_b;
  logic [DW-1:0] w_mask;

  // B wins when it is the only requester or when both request and prio points at B
  assign w_grant_b = arb.req_b & (~arb.req_a | r_prio);

`ifdef ARB_ROM_MASK_EN
  // rom_addr is registered, so rom_data is settled for the whole ACCESS cycle
  assign w_mask       = (r_state == S_ACCESS) ? arb.rom_data : DW'(0);
  assign arb.rom_addr = r_addr;
`else
  logic w_unused_rom;
  assign w_unused_rom = ^arb.rom_data;
  assign w_mask       = DW'(0);
  assign arb.rom_addr = AW'(0);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_win      <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= AW'(0);
      r_wdata    <= DW'(0);
      r_rdata    <= DW'(0);
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_busy     <= 1'b0;
      r_ram_mode <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_win      <= w_win_nxt;
      r_wr       <= w_wr_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_ack_a    <= w_ack_a_nxt;
      r_ack_b    <= w_ack_b_nxt;
      r_busy     <= w_busy_nxt;
      r_ram_mode <= w_ram_mode_nxt;
    end
  end

  // Next-state and registered-output logic; RAM stays in read mode outside ACCESS
  always_comb begin
    w_state_nxt    = r_state;
    w_prio_nxt     = r_prio;
    w_win_nxt      = r_win;
    w_wr_nxt       = r_wr;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_ack_a_nxt    = 1'b0;
    w_ack_b_nxt    = 1'b0;
    w_busy_nxt     = 1'b0;
    w_ram_mode_nxt = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (arb.req_a | arb.req_b) begin
          w_state_nxt    = S_ACCESS;
          w_win_nxt      = w_grant_b;
          w_wr_nxt       = w_grant_b ? arb.wr_b    : arb.wr_a;
          w_addr_nxt     = w_grant_b ? arb.addr_b  : arb.addr_a;
          w_wdata_nxt    = w_grant_b ? arb.wdata_b : arb.wdata_a;
          w_busy_nxt     = 1'b1;
          w_ram_mode_nxt = ~w_wr_nxt;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_RESP;
        w_busy_nxt  = 1'b1;
        w_ack_a_nxt = ~r_win;
        w_ack_b_nxt = r_win;
        if (!r_wr) begin
          w_rdata_nxt = arb.ram_data_out ^ w_mask;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_prio_nxt  = ~r_win;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign arb.ack_a       = r_ack_a;
  assign arb.ack_b       = r_ack_b;
  assign arb.busy        = r_busy;
  assign arb.rdata       = r_rdata;
  assign arb.ram_mode    = r_ram_mode;
  assign arb.ram_addr    = r_addr;
  assign arb.ram_data_in = r_wdata;
  assign arb.ram_mask    = w_mask;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized self-checking bench for mem_access_arbiter with behavioural XOR_RAM/ROM and a
// cycle-count service model; honours ARB_ROM_MASK_EN for the expected encoding.
module tb_mem_access_arbiter;
  typedef struct packed {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
  } op_t;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  mem_access_arbiter_if bus ();
  mem_access_arbiter dut (.CLK(CLK), .RST_N(RST_N), .arb(bus));

  // Environment: ROM and XOR_RAM (stores data_in ^ mask, combinational read)
  logic [7:0] rom [8] = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0, 8'hFF};
  logic [7:0] ram [8] = '{default: 8'h00};
  always @(posedge CLK) if (!bus.ram_mode) ram[bus.ram_addr] <= bus.ram_data_in ^ bus.ram_mask;
  assign bus.ram_data_out = ram[bus.ram_addr];
  assign bus.rom_data     = rom[bus.rom_addr];

  // Requester drive
  bit         pend    [2] = '{1'b0, 1'b0};
  logic       op_wr   [2] = '{1'b0, 1'b0};
  logic [2:0] op_addr [2] = '{3'd0, 3'd0};
  logic [7:0] op_data [2] = '{8'h00, 8'h00};
  assign bus.req_a   = pend[0];
  assign bus.req_b   = pend[1];
  assign bus.wr_a    = op_wr[0];
  assign bus.wr_b    = op_wr[1];
  assign bus.addr_a  = op_addr[0];
  assign bus.addr_b  = op_addr[1];
  assign bus.wdata_a = op_data[0];
  assign bus.wdata_b = op_data[1];

  // Reference model: plain memory contents plus a service timeline
  logic [7:0] mem_ref [8] = '{default: 8'h00};
  op_t        qa[$], qb[$];
  int         obs_id[$], obs_cyc[$];
  int         cyc = 0, g_cyc = 0, next_free = 0;
  bit         inflight = 1'b0, m_prio = 1'b0, g_id = 1'b0, g_wr = 1'b0;
  logic [2:0] g_addr = 3'd0;
  logic [7:0] g_data = 8'h00, rdata_exp = 8'h00;
  int         n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_mask(input logic [2:0] a);
`ifdef ARB_ROM_MASK_EN
    return rom[a];
`else
    return 8'h00 & {8{a[0]}};
`endif
  endfunction

  function automatic logic [2:0] exp_rom_addr(input logic [2:0] a);
`ifdef ARB_ROM_MASK_EN
    return a;
`else
    return 3'd0 & a;
`endif
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.wr   = 1'($urandom_range(0, 1));
    o.addr = 3'($urandom_range(0, 7));
    o.data = 8'($urandom_range(0, 255));
    return o;
  endfunction

  // One clock: compare outputs with the model, retire/issue requests, model the grant
  task automatic step();
    bit  acc, ackc;
    op_t o;
    @(negedge CLK);
    cyc++;
    acc  = inflight && (cyc == g_cyc + 1);
    ackc = inflight && (cyc == g_cyc + 2);
    if (ackc) begin
      if (g_wr) mem_ref[g_addr] = g_data;
      else      rdata_exp = mem_ref[g_addr];
    end
    check("ack_a", 32'(bus.ack_a), 32'(ackc && !g_id));
    check("ack_b", 32'(bus.ack_b), 32'(ackc && g_id));
    check("ack_both", 32'(bus.ack_a & bus.ack_b), 32'd0);
    check("busy", 32'(bus.busy), 32'(acc || ackc));
    check("ram_mode", 32'(bus.ram_mode), 32'(acc ? !g_wr : 1'b1));
    check("ram_mask", 32'(bus.ram_mask), 32'(acc ? exp_mask(g_addr) : 8'h00));
    check("rdata", 32'(bus.rdata), 32'(rdata_exp));
    if (acc) begin
      check("ram_addr", 32'(bus.ram_addr), 32'(g_addr));
      check("ram_din", 32'(bus.ram_data_in), 32'(g_data));
      check("rom_addr", 32'(bus.rom_addr), 32'(exp_rom_addr(g_addr)));
    end
    if (bus.ack_a) begin obs_id.push_back(0); obs_cyc.push_back(cyc); end
    if (bus.ack_b) begin obs_id.push_back(1); obs_cyc.push_back(cyc); end
    if (ackc) begin
      inflight   = 1'b0;
      pend[g_id] = 1'b0;
    end
    if (!pend[0] && qa.size() != 0) begin
      o = qa.pop_front();
      op_wr[0] = o.wr; op_addr[0] = o.addr; op_data[0] = o.data; pend[0] = 1'b1;
    end
    if (!pend[1] && qb.size() != 0) begin
      o = qb.pop_front();
      op_wr[1] = o.wr; op_addr[1] = o.addr; op_data[1] = o.data; pend[1] = 1'b1;
    end
    // Server free: grant a lone requester, or the prio side when both wait; alternate after
    if (cyc >= next_free && (pend[0] || pend[1])) begin
      g_id      = (pend[0] && pend[1]) ? m_prio : pend[1];
      g_wr      = op_wr[g_id];
      g_addr    = op_addr[g_id];
      g_data    = op_data[g_id];
      inflight  = 1'b1;
      g_cyc     = cyc;
      next_free = cyc + 3;
      m_prio    = !g_id;
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((qa.size() + qb.size() != 0 || pend[0] || pend[1] || inflight) && n < limit) begin
      step();
      n++;
    end
    check("drain_left", 32'(qa.size() + qb.size() + int'(pend[0]) + int'(pend[1])), 32'd0);
  endtask

  task automatic model_clear();
    pend[0] = 1'b0; pend[1] = 1'b0;
    qa.delete(); qb.delete();
    inflight = 1'b0; m_prio = 1'b0; rdata_exp = 8'h00; next_free = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_clear();
    #3;
    check("rst_ack_a", 32'(bus.ack_a), 32'd0);
    check("rst_ack_b", 32'(bus.ack_b), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'h00);
    check("rst_ram_mode", 32'(bus.ram_mode), 32'd1);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_din", 32'(bus.ram_data_in), 32'h00);
    check("rst_ram_mask", 32'(bus.ram_mask), 32'h00);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST_N = 1'b1;
    #2;
    do_reset();

    // Read every address through A after reset
    for (int i = 0; i < 8; i++) qa.push_back('{1'b0, 3'(i), 8'($urandom_range(0, 255))});
    drain(60);

    // Write then read back address 3
    qa.push_back('{1'b1, 3'd3, 8'hA5});
    drain(10);
`ifdef ARB_ROM_MASK_EN
    check("cell3", 32'(ram[3]), 32'h96);
`else
    check("cell3", 32'(ram[3]), 32'hA5);
`endif
    qa.push_back('{1'b0, 3'd3, 8'h00});
    drain(10);
    check("rd3", 32'(bus.rdata), 32'hA5);

    // Simultaneous writes after reset: A first, B three cycles later
    do_reset();
    obs_id.delete(); obs_cyc.delete();
    qa.push_back('{1'b1, 3'd1, 8'h11});
    qb.push_back('{1'b1, 3'd2, 8'h22});
    drain(20);
    check("sim_nacks", 32'(obs_id.size()), 32'd2);
    check("sim_first", 32'(obs_id[0]), 32'd0);
    check("sim_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd3);
    qa.push_back('{1'b0, 3'd1, 8'h00});
    drain(10);
    check("rd1", 32'(bus.rdata), 32'h11);
    qb.push_back('{1'b0, 3'd2, 8'h00});
    drain(10);
    check("rd2", 32'(bus.rdata), 32'h22);

    // Both requests held for four transactions: strict alternation from A
    do_reset();
    obs_id.delete(); obs_cyc.delete();
    for (int i = 0; i < 2; i++) begin
      qa.push_back(rand_op());
      qb.push_back(rand_op());
    end
    drain(40);
    check("held_nacks", 32'(obs_id.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("held_order", 32'(obs_id[i]), 32'(i % 2));

    // Reset during ACCESS of a write drops it
    qa.push_back('{1'b1, 3'd5, 8'h5A});
    n = 0;
    while (!(inflight && cyc == g_cyc + 1) && n < 10) begin step(); n++; end
    check("mid_in_access", 32'(bus.ram_mode), 32'd0);
    #1 RST_N = 1'b0;
    #1;
    check("mid_ram_mode", 32'(bus.ram_mode), 32'd1);
    check("mid_ack_a", 32'(bus.ack_a), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    model_clear();
    @(posedge CLK);
    #1;
    check("mid_cell5", 32'(ram[5]), 32'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("mid_cell5_after", 32'(ram[5]), 32'h00);

    // Random traffic from both requesters
    for (int i = 0; i < 400; i++) begin
      if (!pend[0] && qa.size() == 0 && $urandom_range(0, 2) == 0) qa.push_back(rand_op());
      if (!pend[1] && qb.size() == 0 && $urandom_range(0, 2) == 0) qb.push_back(rand_op());
      step();
    end
    drain(40);
    for (int i = 0; i < 8; i++) check("cell_enc", 32'(ram[i]), 32'(mem_ref[i] ^ exp_mask(3'(i))));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
